// File: rtl/if_stage.sv
// Instruction fetch stage: single-outstanding request/grant/rvalid fetch FSM.
// It presents one captured instruction at a time to the IF/ID register.
module if_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stop,
    input  logic        jump,
    input  logic [31:0] jump_addr,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic [31:0] pc_o,
    output logic [31:0] pc4_o,
    output logic [31:0] inst_o,
    output logic        inst_valid
);

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        WAIT  = 2'd1,
        DROP  = 2'd2,
        VALID = 2'd3
    } state_e;

    function automatic logic [31:0] align_word(input logic [31:0] addr);
        return addr & 32'hFFFF_FFFC;
    endfunction

    function automatic logic [31:0] next_word(input logic [31:0] addr);
        return addr + 32'd4;
    endfunction

    state_e      state_r;
    state_e      state_s;
    logic [31:0] pc_r;
    logic [31:0] pc_s;
    logic [31:0] pc4_r;
    logic [31:0] inst_r;
    logic [31:0] inst_s;
    logic        req_r;
    logic        valid_r;
    logic        accept_s;
    logic [31:0] tgt_s;

    // Next-state, next-PC and captured instruction; jump always beats stop.
    always_comb begin
        state_s  = state_r;
        pc_s     = pc_r;
        inst_s   = 32'h0000_0000;
        accept_s = req_r & imem_gnt;
        tgt_s    = align_word(jump_addr);
        case (state_r)
            FETCH: begin
                if (jump) begin
                    pc_s = tgt_s;
                    // An accepted request issued at the old PC is now stale.
                    if (accept_s) begin
                        state_s = DROP;
                    end else begin
                        state_s = FETCH;
                    end
                end else if (accept_s) begin
                    state_s = WAIT;
                end else begin
                    state_s = FETCH;
                end
            end
            WAIT: begin
                if (jump) begin
                    pc_s = tgt_s;
                    if (imem_rvalid) begin
                        state_s = FETCH;
                    end else begin
                        state_s = DROP;
                    end
                end else if (imem_rvalid) begin
                    inst_s  = imem_rdata;
                    state_s = VALID;
                end else begin
                    state_s = WAIT;
                end
            end
            DROP: begin
                if (jump) begin
                    pc_s = tgt_s;
                end else begin
                    pc_s = pc_r;
                end
                if (imem_rvalid) begin
                    state_s = FETCH;
                end else begin
                    state_s = DROP;
                end
            end
            VALID: begin
                if (jump) begin
                    pc_s    = tgt_s;
                    state_s = FETCH;
                end else if (stop) begin
                    inst_s  = inst_r;
                    state_s = VALID;
                end else begin
                    pc_s    = next_word(pc_r);
                    state_s = FETCH;
                end
            end
            default: begin
                state_s = FETCH;
                pc_s    = align_word(RESET_PC);
            end
        endcase
    end

    // State and all outputs are registered from the next-state values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r <= FETCH;
            pc_r    <= align_word(RESET_PC);
            pc4_r   <= next_word(align_word(RESET_PC));
            inst_r  <= 32'h0000_0000;
            req_r   <= 1'b0;
            valid_r <= 1'b0;
        end else begin
            state_r <= state_s;
            pc_r    <= pc_s;
            pc4_r   <= next_word(pc_s);
            inst_r  <= inst_s;
            req_r   <= (state_s == FETCH);
            valid_r <= (state_s == VALID);
        end
    end

    assign imem_req   = req_r;
    assign imem_addr  = pc_r;
    assign pc_o       = pc_r;
    assign pc4_o      = pc4_r;
    assign inst_o     = inst_r;
    assign inst_valid = valid_r;

endmodule
